// File: rtl/lsu_req_ctrl.sv
// Load/store stage controller: issues one bus access at a time, aligns load data, holds one WB result.
// Optional misalignment trap is compiled in with `define LSU_MISALIGN_EXCEPT_EN.
module lsu_req_ctrl #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic [CPU_WIDTH-1:0] i_lsu_exres,
  input  logic [CPU_WIDTH-1:0] i_lsu_rs2,
  input  logic [REG_ADDRW-1:0] i_lsu_rdid,
  input  logic                 i_lsu_rdwen,
  input  logic [2:0]           i_lsu_func3,
  input  logic                 i_lsu_lden,
  input  logic                 i_lsu_sten,
  input  logic [CPU_WIDTH-1:0] i_mem_pc,
  output logic                 o_dreq_valid,
  input  logic                 i_dreq_ready,
  output logic [CPU_WIDTH-1:0] o_dreq_addr,
  output logic                 o_dreq_wen,
  output logic [CPU_WIDTH-1:0] o_dreq_wdata,
  output logic [7:0]           o_dreq_wstrb,
  output logic [1:0]           o_dreq_size,
  input  logic                 i_dresp_valid,
  input  logic [CPU_WIDTH-1:0] i_dresp_rdata,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [CPU_WIDTH-1:0] o_wb_data,
  output logic [REG_ADDRW-1:0] o_wb_rdid,
  output logic                 o_wb_rdwen,
  output logic [CPU_WIDTH-1:0] o_wb_pc,
  output logic                 o_wb_except_en,
  output logic [CPU_WIDTH-1:0] o_wb_except_code
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;

  state_t               r_state;
  logic                 r_dreq_valid;
  logic [CPU_WIDTH-1:0] r_dreq_addr;
  logic                 r_dreq_wen;
  logic [CPU_WIDTH-1:0] r_dreq_wdata;
  logic [7:0]           r_dreq_wstrb;
  logic [1:0]           r_dreq_size;
  logic [2:0]           r_func3;
  logic [REG_ADDRW-1:0] r_rdid;
  logic                 r_rdwen;
  logic [CPU_WIDTH-1:0] r_pc;
  logic                 r_wb_valid;
  logic [CPU_WIDTH-1:0] r_wb_data;
  logic [REG_ADDRW-1:0] r_wb_rdid;
  logic                 r_wb_rdwen;
  logic [CPU_WIDTH-1:0] r_wb_pc;

  logic                 w_accept;
  logic                 w_is_mem;
  logic                 w_except;
  logic [2:0]           w_off;
  logic [7:0]           w_strb_base;
  logic [7:0]           w_wstrb;
  logic [CPU_WIDTH-1:0] w_wdata;
  logic [CPU_WIDTH-1:0] w_shifted;
  logic [CPU_WIDTH-1:0] w_load_data;

  assign mem_ready_o = (r_state == S_IDLE) && (!r_wb_valid || wb_ready_i);
  assign w_accept    = mem_valid_i && mem_ready_o;
  assign w_is_mem    = i_lsu_lden || i_lsu_sten;
  assign w_off       = i_lsu_exres[2:0];

`ifdef LSU_MISALIGN_EXCEPT_EN
  logic                 r_wb_exc_en;
  logic [CPU_WIDTH-1:0] r_wb_exc_code;
  logic                 w_misalign;

  always_comb begin
    w_misalign = 1'b0;
    case (i_lsu_func3[1:0])
      2'b01:   w_misalign = w_off[0];
      2'b10:   w_misalign = |w_off[1:0];
      2'b11:   w_misalign = |w_off;
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_except         = w_is_mem && w_misalign;
  assign o_wb_except_en   = r_wb_exc_en;
  assign o_wb_except_code = r_wb_exc_code;
`else
  assign w_except         = 1'b0;
  assign o_wb_except_en   = 1'b0;
  assign o_wb_except_code = '0;
`endif

  always_comb begin
    w_strb_base = 8'h01;
    case (i_lsu_func3[1:0])
      2'b00:   w_strb_base = 8'h01;
      2'b01:   w_strb_base = 8'h03;
      2'b10:   w_strb_base = 8'h0F;
      default: w_strb_base = 8'hFF;
    endcase
  end

  // Lanes pushed past byte 7 fall off the 8-bit strobe.
  assign w_wstrb   = w_strb_base << w_off;
  assign w_wdata   = i_lsu_rs2 << {w_off, 3'b000};
  assign w_shifted = i_dresp_rdata >> {r_dreq_addr[2:0], 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_func3)
      3'b000:  w_load_data = {{(CPU_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{(CPU_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load_data = {{(CPU_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_load_data = {{(CPU_WIDTH-8){1'b0}}, w_shifted[7:0]};
      3'b101:  w_load_data = {{(CPU_WIDTH-16){1'b0}}, w_shifted[15:0]};
      3'b110:  w_load_data = {{(CPU_WIDTH-32){1'b0}}, w_shifted[31:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // Request FSM and the single-entry writeback register share one clocked block.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_state      <= S_IDLE;
      r_dreq_valid <= 1'b0;
      r_dreq_addr  <= '0;
      r_dreq_wen   <= 1'b0;
      r_dreq_wdata <= '0;
      r_dreq_wstrb <= '0;
      r_dreq_size  <= '0;
      r_func3      <= '0;
      r_rdid       <= '0;
      r_rdwen      <= 1'b0;
      r_pc         <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_data    <= '0;
      r_wb_rdid    <= '0;
      r_wb_rdwen   <= 1'b0;
      r_wb_pc      <= '0;
`ifdef LSU_MISALIGN_EXCEPT_EN
      r_wb_exc_en   <= 1'b0;
      r_wb_exc_code <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mem && !w_except) begin
            r_dreq_valid <= 1'b1;
            r_dreq_addr  <= i_lsu_exres;
            r_dreq_wen   <= i_lsu_sten;
            r_dreq_wdata <= w_wdata;
            r_dreq_wstrb <= w_wstrb;
            r_dreq_size  <= i_lsu_func3[1:0];
            r_func3      <= i_lsu_func3;
            r_rdid       <= i_lsu_rdid;
            r_rdwen      <= i_lsu_rdwen && i_lsu_lden;
            r_pc         <= i_mem_pc;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_dreq_ready) begin
            r_dreq_valid <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_dresp_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_accept && (!w_is_mem || w_except)) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= i_lsu_exres;
        r_wb_rdid  <= i_lsu_rdid;
        r_wb_rdwen <= i_lsu_rdwen && !w_except;
        r_wb_pc    <= i_mem_pc;
`ifdef LSU_MISALIGN_EXCEPT_EN
        r_wb_exc_en   <= w_except;
        r_wb_exc_code <= w_except ? (i_lsu_lden ? CPU_WIDTH'(4) : CPU_WIDTH'(6)) : '0;
`endif
      end else if ((r_state == S_RESP) && i_dresp_valid) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= r_dreq_wen ? '0 : w_load_data;
        r_wb_rdid  <= r_rdid;
        r_wb_rdwen <= r_rdwen;
        r_wb_pc    <= r_pc;
`ifdef LSU_MISALIGN_EXCEPT_EN
        r_wb_exc_en   <= 1'b0;
        r_wb_exc_code <= '0;
`endif
      end else if (wb_ready_i) begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  assign o_dreq_valid = r_dreq_valid;
  assign o_dreq_addr  = r_dreq_addr;
  assign o_dreq_wen   = r_dreq_wen;
  assign o_dreq_wdata = r_dreq_wdata;
  assign o_dreq_wstrb = r_dreq_wstrb;
  assign o_dreq_size  = r_dreq_size;
  assign wb_valid_o   = r_wb_valid;
  assign o_wb_data    = r_wb_data;
  assign o_wb_rdid    = r_wb_rdid;
  assign o_wb_rdwen   = r_wb_rdwen;
  assign o_wb_pc      = r_wb_pc;

endmodule

// File: doc/lsu_req_ctrl.md
# lsu_req_ctrl

Load/store stage controller on the consumer side of the EX→LS pipeline register.
- Accepts one instruction at a time over the valid/ready handshake driven by that register.
- Issues single-beat load/store requests to the data-bus bridge and waits for the response.
- Aligns and sign-extends load data, forms store data/strobes, and holds one result for the LS→WB stage.
- Non-memory instructions pass through with one-cycle latency.

## Interface
Parameters
- CPU_WIDTH, 64, datapath/address width (fixed 64; strobe logic assumes 8 byte lanes)
- REG_ADDRW, 5, register index width

Ports
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-high (asserted = 1)
- mem_valid_i  in  1  upstream instruction valid
- mem_ready_o  out  1  upstream accept
- i_lsu_exres  in  CPU_WIDTH  ALU result / effective address
- i_lsu_rs2  in  CPU_WIDTH  store source
- i_lsu_rdid  in  REG_ADDRW  destination register
- i_lsu_rdwen  in  1  register write enable
- i_lsu_func3  in  3  access size/sign
- i_lsu_lden, i_lsu_sten  in  1 each  load / store flags (never both)
- i_mem_pc  in  CPU_WIDTH  instruction PC
- o_dreq_valid  out  1  bus request valid
- i_dreq_ready  in  1  bus request accepted
- o_dreq_addr  out  CPU_WIDTH  byte address (unaligned, as computed)
- o_dreq_wen  out  1  1 = store
- o_dreq_wdata  out  CPU_WIDTH  lane-shifted store data
- o_dreq_wstrb  out  8  byte strobes
- o_dreq_size  out  2  func3[1:0]
- i_dresp_valid  in  1  response valid (loads and stores)
- i_dresp_rdata  in  CPU_WIDTH  aligned 8-byte read beat
- wb_valid_o  out  1  result valid
- wb_ready_i  in  1  WB accept
- o_wb_data  out  CPU_WIDTH  writeback value
- o_wb_rdid  out  REG_ADDRW; o_wb_rdwen  out  1; o_wb_pc  out  CPU_WIDTH
- o_wb_except_en  out  1; o_wb_except_code  out  CPU_WIDTH  misalignment exception (see Configuration)

## Operation
- States: IDLE, REQ, RESP.
- mem_ready_o = (state==IDLE) && (!wb_valid_o || wb_ready_i).
- Accept of a non-memory instruction:
  - The output register loads exres, rdid, rdwen and pc next cycle; wb_valid_o=1.
  - State stays IDLE.
- Accept of a load/store:
  - Capture the fields and go to REQ.
  - REQ drives o_dreq_valid=1 with constant request fields until i_dreq_ready, then goes to RESP.
  - RESP waits for i_dresp_valid, loads the output register, sets wb_valid_o=1, and returns to IDLE.
  - Stores write rdwen=0 and o_wb_data=0.
- Load align:
  - off=addr[2:0]; r = rdata >> (8*off).
  - func3 000/001/010/011 = sign-extend 8/16/32/64 bits.
  - func3 100/101/110 = zero-extend 8/16/32 bits.
- Store form:
  - wdata = rs2 << (8*off).
  - wstrb = (0x01/0x03/0x0F/0xFF by size) << off, truncated to 8 bits.
- wb_valid_o clears on wb_ready_i when no new result loads in the same cycle.
- Simultaneous drain and load in one cycle is legal (back-to-back).
- i_dresp_valid in IDLE or REQ is ignored. i_dreq_ready outside REQ is ignored.
- Reset, including mid-transaction:
  - state=IDLE; wb_valid_o=0; o_dreq_valid=0; all data outputs 0.
  - The in-flight access is abandoned; its late response is ignored.

## Timing
- Non-memory: accepted at cycle T → wb_valid_o at T+1.
- Memory with zero-wait bus: accepted at T → o_dreq_valid at T+1 (ready same cycle) → RESP at T+2.
  - i_dresp_valid at T+2 → wb_valid_o at T+3. Minimum 3 cycles.
- mem_ready_o is 0 for the entire REQ/RESP duration. At most one outstanding bus request.
- Output fields are stable while wb_valid_o && !wb_ready_i.

## Configuration
- LSU_MISALIGN_EXCEPT_EN defined:
  - Misaligned accesses (H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0) issue no bus request.
  - They complete like a non-memory instruction in 1 cycle with o_wb_except_en=1 and o_wb_rdwen=0.
  - o_wb_except_code is 4 for a load, 6 for a store.
- Undefined:
  - o_wb_except_en and o_wb_except_code are tied 0.
  - Misaligned accesses are issued as-is with truncated strobes; bytes beyond lane 7 are dropped.

## Test plan
- Non-mem, exres=0x1234, rdid=5: wb_valid_o next cycle, o_wb_data=0x1234, rdwen=1; back-to-back stream with wb_ready_i=1 sustains 1/cycle.
- LB at addr 0x...03, rdata=0x00000000_80000000 → o_wb_data=0xFFFF_FFFF_FFFF_FF80. LBU same → 0x80.
- SH at addr 0x...06, rs2=0xABCD, i_dreq_ready delayed 3 cycles → wstrb=0xC0, wdata=0xABCD<<48, request stable while waiting, rdwen=0 result.
- wb_ready_i=0 with a result held → mem_ready_o=0 and no new accept; release → drain and accept in the same cycle.
- Reset asserted in RESP, then i_dresp_valid pulses → no wb_valid_o, state IDLE, all outputs 0.
- LW at 0x...02:
  - With LSU_MISALIGN_EXCEPT_EN → no o_dreq_valid, except_en=1, code=4 at T+1.
  - Without it → request issued with wstrb irrelevant, size=2.
